// File: rtl/combo_lock_ctrl.sv
// rtl/combo_lock_ctrl.sv - combination lock controller with provisioning, lockout and auto-relock
module combo_lock_ctrl #(
    parameter int                CODE_W        = 16,
    parameter logic [CODE_W-1:0] BANK_CODE     = CODE_W'(16'hAAAA),
    parameter logic [CODE_W-1:0] OVERRIDE_CODE = CODE_W'(16'hFFFF),
    parameter int                MAX_TRIES     = 3,
    parameter int                LOCKOUT_CYC   = 1000,
    parameter int                UNLOCK_CYC    = 500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] in,
    input  logic              enter,
    output logic [1:0]        lock,
    output logic [2:0]        state_out,
    output logic [3:0]        fail_cnt,
    output logic              programmed
);

    localparam int TMAX  = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TMR_W = $clog2(TMAX);
    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [3:0]       MAX_T     = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PROG    = 3'd1,
        S_ARMED   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              prog_q, prog_d;
    logic [3:0]        fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        lock_q;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        prog_d  = prog_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (enter && in == BANK_CODE) begin
                    state_d = S_PROG;
                    fail_d  = 4'd0;
                end
            end
            S_PROG: begin
                if (enter) begin
                    code_d  = in;
                    prog_d  = 1'b1;
                    fail_d  = 4'd0;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (enter) begin
                    if (in == code_q) begin
                        state_d = S_OPEN;
                        fail_d  = 4'd0;
                    end else begin
                        if (fail_q < MAX_T) fail_d = fail_q + 4'd1;
                        if (fail_q + 4'd1 == MAX_T) state_d = S_LOCKOUT;
                    end
                end
            end
            S_OPEN: begin
                // an entry takes priority over relock expiry in the same cycle
                if (enter) begin
                    if (in == BANK_CODE) begin
                        state_d = S_PROG;
                        fail_d  = 4'd0;
                    end else begin
                        state_d = S_ARMED;
                    end
                end else if (timer_q == OPEN_LAST) begin
                    state_d = S_ARMED;
                end
            end
            S_LOCKOUT: begin
                if (enter && in == OVERRIDE_CODE) begin
                    state_d = S_PROG;
                    fail_d  = 4'd0;
                end else if (timer_q == LOCK_LAST) begin
                    state_d = S_ARMED;
                    fail_d  = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // wrong entries during lockout do not restart the release countdown
        if (state_d != state_q || (state_q != S_OPEN && state_q != S_LOCKOUT)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            prog_q  <= 1'b0;
            fail_q  <= 4'd0;
            timer_q <= '0;
            lock_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            prog_q  <= prog_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            case (state_d)
                S_OPEN:    lock_q <= 2'b01;
                S_LOCKOUT: lock_q <= 2'b10;
                default:   lock_q <= 2'b00;
            endcase
        end
    end

    assign lock       = lock_q;
    assign state_out  = state_q;
    assign fail_cnt   = fail_q;
    assign programmed = prog_q;

endmodule

// File: doc/combo_lock_ctrl.md
COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

Interface
REQ-001 Parameter CODE_W, default 16: width of code input and stored user code, legal 4..32.
REQ-002 Parameter BANK_CODE, default 16'hAAAA (CODE_W bits): provisioning code.
REQ-003 Parameter OVERRIDE_CODE, default 16'hFFFF (CODE_W bits): lockout override code.
REQ-004 Parameter MAX_TRIES, default 3: consecutive wrong entries that trigger lockout, legal 1..15.
REQ-005 Parameter LOCKOUT_CYC, default 1000: lockout auto-release time in clk cycles, legal >=2.
REQ-006 Parameter UNLOCK_CYC, default 500: auto-relock time in clk cycles, legal >=2.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in  input  CODE_W  code value, sampled only when enter=1.
REQ-010 enter  input  1  single-cycle entry strobe; enter held high for N cycles is N entries.
REQ-011 lock  output  2  status: 2'b00 locked, 2'b01 unlocked, 2'b10 lockout (held).
REQ-012 state_out  output  3  current state encoding.
REQ-013 fail_cnt  output  4  consecutive wrong-entry count.
REQ-014 programmed  output  1  high when a user code is stored.

Function
REQ-015 States and state_out encoding: IDLE=0, PROG=1, ARMED=2, OPEN=3, LOCKOUT=4; codes 5..7 SHALL return to IDLE on next edge.
REQ-016 Transitions evaluated only on enter=1, except timer expiry (REQ-022, REQ-024); with enter=0 and no expiry, state holds.
REQ-017 Latency: entry accepted at edge N, state_out/lock/fail_cnt reflect result immediately after edge N.
REQ-018 lock SHALL be a Moore decode of state: OPEN->01, LOCKOUT->10, all others->00.
REQ-019 IDLE: in==BANK_CODE -> PROG; other value -> IDLE, no fail count.
REQ-020 PROG: any value (including BANK_CODE) stored as user code, programmed<=1, fail_cnt<=0, -> ARMED.
REQ-021 ARMED: in==user code -> OPEN, fail_cnt<=0; mismatch -> fail_cnt+1, and if fail_cnt+1==MAX_TRIES -> LOCKOUT, else stay ARMED.
REQ-022 OPEN: enter with in==BANK_CODE -> PROG; any other enter -> ARMED; no enter for UNLOCK_CYC consecutive cycles -> ARMED.
REQ-023 OPEN timer restarts at 0 on entry to OPEN; expiry on the cycle the count reaches UNLOCK_CYC-1.
REQ-024 LOCKOUT: in==OVERRIDE_CODE -> PROG; other entries ignored (timer not restarted); after LOCKOUT_CYC cycles in LOCKOUT -> ARMED with fail_cnt<=0.
REQ-025 Simultaneous enter and timer expiry in same cycle: the enter transition wins.
REQ-026 fail_cnt saturates at MAX_TRIES, never wraps; cleared on any entry to OPEN, PROG, or on lockout release.
REQ-027 Timers sized ceil(log2(max(LOCKOUT_CYC,UNLOCK_CYC))) bits; single shared counter permitted, cleared on every state change.
REQ-028 Stored user code changes only in PROG; no combinational path from in to lock.

Reset
REQ-029 On reset=1 at a clock edge: state IDLE, lock=00, state_out=0, fail_cnt=0, programmed=0, user code=0, timer=0.
REQ-030 Reset SHALL override enter and timer expiry in the same cycle, including mid-LOCKOUT or mid-OPEN.
REQ-031 Before first reset outputs are undefined; the bench SHALL assert reset >=1 cycle before stimulus.

Verification
REQ-032 Provision: reset; enter 16'hAAAA; enter 16'h1234; enter 16'h1234 -> state_out 0,1,2,3; lock=01; programmed=1.
REQ-033 Lockout: programmed 16'h1234, enter 16'h0001 three times -> fail_cnt 1,2 then state LOCKOUT, lock=10, fail_cnt=3; extra entries ignored.
REQ-034 Lockout release: in LOCKOUT, no override for 1000 cycles -> ARMED, fail_cnt=0, lock=00 exactly at cycle 1000; separately enter 16'hFFFF -> PROG.
REQ-035 Auto-relock: in OPEN, no enter for 500 cycles -> ARMED at cycle 500; enter on cycle 500 with 16'hAAAA -> PROG (enter wins).
REQ-036 Reset mid-op: reset asserted during LOCKOUT with enter=1, in=16'hFFFF -> IDLE, programmed=0, lock=00 next cycle.
REQ-037 Parameter sweep: CODE_W=8, MAX_TRIES=1, LOCKOUT_CYC=2, UNLOCK_CYC=2 -> one wrong entry locks out, release after 2 cycles.
